// File: rtl/gpio_cmd_sequencer_pkg.sv
// gpio_cmd_pkg: shared constants for the GPIO command sequencer.
//   - command opcodes accepted on the UART byte link
//   - ACK / NAK response bytes
//   - FSM state encoding
package gpio_cmd_pkg;

    localparam logic [7:0] OP_WR_OUT = 8'h57;  // 'W' write gpio_out, one argument byte
    localparam logic [7:0] OP_WR_OE  = 8'h44;  // 'D' write gpio_oe, one argument byte
    localparam logic [7:0] OP_RD_PIN = 8'h52;  // 'R' read synchronised pins
    localparam logic [7:0] OP_RD_OUT = 8'h53;  // 'S' read back gpio_out

    localparam logic [7:0] BYTE_ACK  = 8'h06;
    localparam logic [7:0] BYTE_NAK  = 8'h15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARG  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/gpio_cmd_sequencer_if.sv
// gpio_cmd_sequencer_if: byte link between the UART rx/tx pair and the sequencer.
//   rx_valid/rx_data : received byte strobe and value (UART rx -> sequencer)
//   tx_ready         : transmitter can take a byte this cycle
//   tx_valid/tx_data : pending response byte (sequencer -> UART tx)
// Modports: master = UART side, slave = sequencer side.
interface gpio_cmd_sequencer_if;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;

    modport master (
        output rx_valid,
        output rx_data,
        output tx_ready,
        input  tx_valid,
        input  tx_data
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  tx_ready,
        output tx_valid,
        output tx_data
    );

endinterface

// File: rtl/gpio_cmd_sequencer_sync2.sv
// sync2: parameterised-width two-flop synchroniser, asynchronous reset to 0.
//   clk  in           sampling clock
//   rst  in           asynchronous active-high reset
//   d_i  in  WIDTH    asynchronous input
//   q_o  out WIDTH    synchronised output (two-cycle latency)
module sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gpio_cmd_sequencer.sv
// gpio_cmd_sequencer: parses 1/2-byte command frames from the UART link, writes the
// GPIO output/direction registers and queues one response byte per frame.
//   clk       in            rising-edge clock
//   rst       in            asynchronous active-high reset
//   bus       slave         rx byte strobe in, tx byte handshake out
//   gpio_in   in  NUM_PINS  raw pad inputs (synchronised internally)
//   gpio_out  out NUM_PINS  pad output values
//   gpio_oe   out NUM_PINS  pad output enables, 1 = drive
//   busy      out           high whenever the FSM is not IDLE
//   err       out           one-cycle pulse: bad opcode, argument timeout, dropped byte
module gpio_cmd_sequencer
    import gpio_cmd_pkg::*;
#(
    parameter int NUM_PINS       = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    gpio_cmd_sequencer_if.slave    bus,
    input  logic [NUM_PINS-1:0]    gpio_in,
    output logic [NUM_PINS-1:0]    gpio_out,
    output logic [NUM_PINS-1:0]    gpio_oe,
    output logic                   busy,
    output logic                   err
);

    // Guard against a zero-width timer for tiny timeouts.
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q,    state_d;
    logic [TIMER_W-1:0]  timer_q,    timer_d;
    logic [7:0]          opcode_q,   opcode_d;
    logic [NUM_PINS-1:0] gpio_out_q, gpio_out_d;
    logic [NUM_PINS-1:0] gpio_oe_q,  gpio_oe_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q,  tx_data_d;
    logic                err_q,      err_d;

    logic [NUM_PINS-1:0] pins_sync;
    logic [7:0]          pins_byte;
    logic [7:0]          out_byte;

    sync2 #(.WIDTH(NUM_PINS)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (gpio_in),
        .q_o (pins_sync)
    );

    // Zero-extend pin-wide values to a response byte; upper bits read as 0.
    always_comb begin
        pins_byte                 = '0;
        out_byte                  = '0;
        pins_byte[NUM_PINS-1:0]   = pins_sync;
        out_byte[NUM_PINS-1:0]    = gpio_out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            opcode_q   <= '0;
            gpio_out_q <= '0;
            gpio_oe_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            opcode_q   <= opcode_d;
            gpio_out_q <= gpio_out_d;
            gpio_oe_q  <= gpio_oe_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        opcode_d   = opcode_q;
        gpio_out_d = gpio_out_q;
        gpio_oe_d  = gpio_oe_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    case (bus.rx_data)
                        OP_WR_OUT, OP_WR_OE: begin
                            opcode_d = bus.rx_data;
                            timer_d  = '0;
                            state_d  = ARG;
                        end
                        OP_RD_PIN: begin
                            tx_valid_d = 1'b1;
                            tx_data_d  = pins_byte;
                            state_d    = RESP;
                        end
                        OP_RD_OUT: begin
                            tx_valid_d = 1'b1;
                            tx_data_d  = out_byte;
                            state_d    = RESP;
                        end
                        default: begin
                            tx_valid_d = 1'b1;
                            tx_data_d  = BYTE_NAK;
                            err_d      = 1'b1;
                            state_d    = RESP;
                        end
                    endcase
                end
            end

            ARG: begin
                // An argument byte on the final timer cycle still wins over the timeout.
                if (bus.rx_valid) begin
                    if (opcode_q == OP_WR_OUT) begin
                        gpio_out_d = bus.rx_data[NUM_PINS-1:0];
                    end else begin
                        gpio_oe_d = bus.rx_data[NUM_PINS-1:0];
                    end
                    tx_valid_d = 1'b1;
                    tx_data_d  = BYTE_ACK;
                    state_d    = RESP;
                end else if (timer_q == TIMER_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            RESP: begin
                // Bytes arriving while a response is pending are never buffered,
                // including on the cycle the transfer completes.
                if (bus.rx_valid) begin
                    err_d = 1'b1;
                end
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign gpio_out     = gpio_out_q;
    assign gpio_oe      = gpio_oe_q;
    assign busy         = (state_q != IDLE);
    assign err          = err_q;

endmodule
